// File: rtl/rx_cmd_decoder.sv
// Decodes UART-received bytes into register-file write/read strobes and ALU commands.
// Every output is registered; any frame error abandons the command in progress.
module rx_cmd_decoder #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  RX_PAR_ERR,
    input  logic                  RX_STP_ERR,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic                  ALU_EN,
    output logic [3:0]            ALU_FUN,
    output logic                  CLK_GATE_EN,
    output logic                  BUSY,
    output logic                  CMD_ERR
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_OP_A,
        ST_OP_B,
        ST_ALU_FUN
    } state_t;

    localparam logic [DATA_WIDTH-1:0] CMD_REG_WR = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_REG_RD = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

    state_t state;
    logic   good_byte;
    logic   bad_byte;

    assign good_byte = RX_D_VLD & ~RX_PAR_ERR & ~RX_STP_ERR;
    assign bad_byte  = RX_D_VLD & (RX_PAR_ERR | RX_STP_ERR);

    // NOTE: all state and outputs use non-blocking assignments so every
    // branch below sees the pre-edge values, including ALU_EN for the gate clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= ST_IDLE;
            WrEn        <= 1'b0;
            RdEn        <= 1'b0;
            Address     <= '0;
            WrData      <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            BUSY        <= 1'b0;
            CMD_ERR     <= 1'b0;
        end else begin
            // Strobes default low so each assertion lasts exactly one cycle.
            WrEn    <= 1'b0;
            RdEn    <= 1'b0;
            ALU_EN  <= 1'b0;
            CMD_ERR <= 1'b0;
            if (ALU_EN) begin
                CLK_GATE_EN <= 1'b0;
            end

            if (bad_byte) begin
                state       <= ST_IDLE;
                BUSY        <= 1'b0;
                CMD_ERR     <= 1'b1;
                CLK_GATE_EN <= 1'b0;
            end else if (good_byte) begin
                case (state)
                    ST_IDLE: begin
                        case (RX_P_DATA)
                            CMD_REG_WR: begin
                                state <= ST_WR_ADDR;
                                BUSY  <= 1'b1;
                            end
                            CMD_REG_RD: begin
                                state <= ST_RD_ADDR;
                                BUSY  <= 1'b1;
                            end
                            CMD_ALU_OP: begin
                                state       <= ST_OP_A;
                                BUSY        <= 1'b1;
                                CLK_GATE_EN <= 1'b1;
                            end
                            CMD_ALU_NO: begin
                                state       <= ST_ALU_FUN;
                                BUSY        <= 1'b1;
                                CLK_GATE_EN <= 1'b1;
                            end
                            default: CMD_ERR <= 1'b1;
                        endcase
                    end
                    ST_WR_ADDR: begin
                        Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state   <= ST_WR_DATA;
                    end
                    ST_WR_DATA: begin
                        WrData <= RX_P_DATA;
                        WrEn   <= 1'b1;
                        state  <= ST_IDLE;
                        BUSY   <= 1'b0;
                    end
                    ST_RD_ADDR: begin
                        Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                        RdEn    <= 1'b1;
                        state   <= ST_IDLE;
                        BUSY    <= 1'b0;
                    end
                    // Operands land in fixed register-file slots 0 and 1.
                    ST_OP_A: begin
                        Address <= '0;
                        WrData  <= RX_P_DATA;
                        WrEn    <= 1'b1;
                        state   <= ST_OP_B;
                    end
                    ST_OP_B: begin
                        Address <= ADDR_WIDTH'(1);
                        WrData  <= RX_P_DATA;
                        WrEn    <= 1'b1;
                        state   <= ST_ALU_FUN;
                    end
                    ST_ALU_FUN: begin
                        ALU_FUN <= RX_P_DATA[3:0];
                        ALU_EN  <= 1'b1;
                        state   <= ST_IDLE;
                        BUSY    <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Directed bench for rx_cmd_decoder: each task drives a byte sequence and checks
// the registered outputs against hand-computed values.
module tb_rx_cmd_decoder;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] RX_P_DATA;
    logic          RX_D_VLD;
    logic          RX_PAR_ERR;
    logic          RX_STP_ERR;
    logic          WrEn;
    logic          RdEn;
    logic [AW-1:0] Address;
    logic [DW-1:0] WrData;
    logic          ALU_EN;
    logic [3:0]    ALU_FUN;
    logic          CLK_GATE_EN;
    logic          BUSY;
    logic          CMD_ERR;

    int vectors;
    int miscompares;
    int wr_cnt;
    int rd_cnt;
    int alu_cnt;
    int both_hi;

    rx_cmd_decoder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_P_DATA  (RX_P_DATA),
        .RX_D_VLD   (RX_D_VLD),
        .RX_PAR_ERR (RX_PAR_ERR),
        .RX_STP_ERR (RX_STP_ERR),
        .WrEn       (WrEn),
        .RdEn       (RdEn),
        .Address    (Address),
        .WrData     (WrData),
        .ALU_EN     (ALU_EN),
        .ALU_FUN    (ALU_FUN),
        .CLK_GATE_EN(CLK_GATE_EN),
        .BUSY       (BUSY),
        .CMD_ERR    (CMD_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Strobe counters catch extra or missing pulses between explicit checks.
    always @(negedge CLK) begin
        if (WrEn) wr_cnt++;
        if (RdEn) rd_cnt++;
        if (ALU_EN) alu_cnt++;
        if (WrEn && RdEn) both_hi++;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One byte presented for exactly one cycle; returns 1 time unit after the edge.
    task automatic send_byte(input logic [DW-1:0] data, input logic par, input logic stp);
        @(negedge CLK);
        RX_P_DATA  = data;
        RX_D_VLD   = 1'b1;
        RX_PAR_ERR = par;
        RX_STP_ERR = stp;
        @(posedge CLK);
        #1;
        RX_D_VLD   = 1'b0;
        RX_PAR_ERR = 1'b0;
        RX_STP_ERR = 1'b0;
    endtask

    task automatic idle_cycle(input logic [DW-1:0] junk);
        @(negedge CLK);
        RX_P_DATA = junk;
        RX_D_VLD  = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b0;
        RX_P_DATA = '0; RX_D_VLD = 1'b0; RX_PAR_ERR = 1'b0; RX_STP_ERR = 1'b0;
        #12;
        cmp("reset_outputs",
            32'({WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, BUSY, CMD_ERR}), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        idle_cycle(8'h00);
        cmp("post_reset_busy", 32'(BUSY), 32'd0);
    endtask

    task automatic test_write;
        int w0;
        w0 = wr_cnt;
        send_byte(8'hAA, 1'b0, 1'b0);
        cmp("wr_busy_after_cmd", 32'(BUSY), 32'd1);
        cmp("wr_no_strobe_cmd", 32'(WrEn), 32'd0);
        send_byte(8'h05, 1'b0, 1'b0);
        cmp("wr_busy_after_addr", 32'(BUSY), 32'd1);
        cmp("wr_no_strobe_addr", 32'(WrEn), 32'd0);
        send_byte(8'h3C, 1'b0, 1'b0);
        cmp("wr_wren", 32'(WrEn), 32'd1);
        cmp("wr_address", 32'(Address), 32'h5);
        cmp("wr_wrdata", 32'(WrData), 32'h3C);
        idle_cycle(8'h00);
        cmp("wr_wren_one_cycle", 32'(WrEn), 32'd0);
        cmp("wr_busy_done", 32'(BUSY), 32'd0);
        cmp("wr_address_held", 32'(Address), 32'h5);
        cmp("wr_wrdata_held", 32'(WrData), 32'h3C);
        cmp("wr_pulse_count", 32'(wr_cnt - w0), 32'd1);
    endtask

    task automatic test_read;
        int w0;
        int r0;
        w0 = wr_cnt;
        r0 = rd_cnt;
        send_byte(8'hBB, 1'b0, 1'b0);
        send_byte(8'h0F, 1'b0, 1'b0);
        cmp("rd_rden", 32'(RdEn), 32'd1);
        cmp("rd_address", 32'(Address), 32'hF);
        cmp("rd_no_wren", 32'(WrEn), 32'd0);
        idle_cycle(8'h00);
        cmp("rd_rden_one_cycle", 32'(RdEn), 32'd0);
        cmp("rd_pulse_count", 32'(rd_cnt - r0), 32'd1);
        cmp("rd_no_writes", 32'(wr_cnt - w0), 32'd0);
    endtask

    task automatic test_alu_ops;
        int a0;
        a0 = alu_cnt;
        send_byte(8'hCC, 1'b0, 1'b0);
        cmp("alu_gate_on", 32'(CLK_GATE_EN), 32'd1);
        send_byte(8'h12, 1'b0, 1'b0);
        cmp("alu_opa_wren", 32'(WrEn), 32'd1);
        cmp("alu_opa_addr", 32'(Address), 32'h0);
        cmp("alu_opa_data", 32'(WrData), 32'h12);
        send_byte(8'h34, 1'b0, 1'b0);
        cmp("alu_opb_wren", 32'(WrEn), 32'd1);
        cmp("alu_opb_addr", 32'(Address), 32'h1);
        cmp("alu_opb_data", 32'(WrData), 32'h34);
        cmp("alu_gate_mid", 32'(CLK_GATE_EN), 32'd1);
        send_byte(8'h02, 1'b0, 1'b0);
        cmp("alu_en", 32'(ALU_EN), 32'd1);
        cmp("alu_fun", 32'(ALU_FUN), 32'h2);
        cmp("alu_gate_at_en", 32'(CLK_GATE_EN), 32'd1);
        cmp("alu_no_wren_at_en", 32'(WrEn), 32'd0);
        idle_cycle(8'h00);
        cmp("alu_en_one_cycle", 32'(ALU_EN), 32'd0);
        cmp("alu_gate_off", 32'(CLK_GATE_EN), 32'd0);
        cmp("alu_fun_held", 32'(ALU_FUN), 32'h2);
        cmp("alu_pulse_count", 32'(alu_cnt - a0), 32'd1);
    endtask

    task automatic test_bad_byte;
        int w0;
        w0 = wr_cnt;
        send_byte(8'hCC, 1'b0, 1'b0);
        send_byte(8'h12, 1'b0, 1'b0);
        send_byte(8'h34, 1'b1, 1'b0);
        cmp("par_cmd_err", 32'(CMD_ERR), 32'd1);
        cmp("par_no_wren", 32'(WrEn), 32'd0);
        cmp("par_gate_off", 32'(CLK_GATE_EN), 32'd0);
        cmp("par_idle", 32'(BUSY), 32'd0);
        cmp("par_opa_kept", 32'({Address, WrData}), 32'({4'h0, 8'h12}));
        cmp("par_one_write", 32'(wr_cnt - w0), 32'd1);
        idle_cycle(8'h00);
        cmp("par_err_one_cycle", 32'(CMD_ERR), 32'd0);
        send_byte(8'hDD, 1'b0, 1'b0);
        cmp("dd_gate_on", 32'(CLK_GATE_EN), 32'd1);
        send_byte(8'h07, 1'b0, 1'b0);
        cmp("dd_alu_en", 32'(ALU_EN), 32'd1);
        cmp("dd_alu_fun", 32'(ALU_FUN), 32'h7);
        // Stop-bit error mid register write.
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h09, 1'b0, 1'b1);
        cmp("stp_cmd_err", 32'(CMD_ERR), 32'd1);
        cmp("stp_idle", 32'(BUSY), 32'd0);
    endtask

    task automatic test_unknown_cmd;
        int w0;
        int r0;
        int a0;
        w0 = wr_cnt; r0 = rd_cnt; a0 = alu_cnt;
        send_byte(8'h55, 1'b0, 1'b0);
        cmp("unk_cmd_err", 32'(CMD_ERR), 32'd1);
        cmp("unk_idle", 32'(BUSY), 32'd0);
        idle_cycle(8'h00);
        cmp("unk_err_one_cycle", 32'(CMD_ERR), 32'd0);
        cmp("unk_no_strobes", 32'((wr_cnt - w0) + (rd_cnt - r0) + (alu_cnt - a0)), 32'd0);
    endtask

    task automatic test_reset_mid_cmd;
        int w0;
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        #2;
        RST = 1'b0;
        #1;
        cmp("mid_reset_outputs",
            32'({WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, BUSY, CMD_ERR}), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        w0 = wr_cnt;
        send_byte(8'h3C, 1'b0, 1'b0);
        cmp("mid_reset_no_wren", 32'(WrEn), 32'd0);
        cmp("mid_reset_cmd_err", 32'(CMD_ERR), 32'd1);
        idle_cycle(8'h00);
        cmp("mid_reset_no_writes", 32'(wr_cnt - w0), 32'd0);
    endtask

    task automatic test_back_to_back;
        int w0;
        w0 = wr_cnt;
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0);
        cmp("b2b_wren", 32'({WrEn, Address, WrData}), 32'({1'b1, 4'h1, 8'h11}));
        send_byte(8'hBB, 1'b0, 1'b0);
        cmp("b2b_rd_busy", 32'({BUSY, WrEn}), 32'({1'b1, 1'b0}));
        send_byte(8'h02, 1'b0, 1'b0);
        cmp("b2b_rden", 32'({RdEn, Address}), 32'({1'b1, 4'h2}));
        // A non-valid cycle carrying stale data must not advance the FSM.
        send_byte(8'hAA, 1'b0, 1'b0);
        idle_cycle(8'h77);
        cmp("hold_busy", 32'(BUSY), 32'd1);
        send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0);
        cmp("hold_wren", 32'({WrEn, Address, WrData}), 32'({1'b1, 4'h3, 8'h44}));
        idle_cycle(8'h00);
        cmp("b2b_write_count", 32'(wr_cnt - w0), 32'd2);
        cmp("never_wr_and_rd", 32'(both_hi), 32'd0);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        wr_cnt = 0; rd_cnt = 0; alu_cnt = 0; both_hi = 0;
        test_reset();
        test_write();
        test_read();
        test_alu_ops();
        test_bad_byte();
        test_unknown_cmd();
        test_reset_mid_cmd();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rx_cmd_decoder.md
RX_CMD_DECODER -- requirements
Module: rx_cmd_decoder

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of received bytes, register write data and the command codes.
REQ-002 Parameter ADDR_WIDTH, default 4: register-file address width; taken from the ADDR_WIDTH LSBs of the address byte.
REQ-003 One clock; reset is asynchronous and active-low (port names CLK, RST).
REQ-004 CLK  in  1  system clock, all state rising-edge.
REQ-005 RST  in  1  asynchronous active-low reset.
REQ-006 RX_P_DATA  in  DATA_WIDTH  received byte, valid only while RX_D_VLD=1.
REQ-007 RX_D_VLD  in  1  one-cycle pulse per received frame, already synchronous to CLK.
REQ-008 RX_PAR_ERR  in  1  parity error for the frame, sampled with RX_D_VLD.
REQ-009 RX_STP_ERR  in  1  stop-bit error for the frame, sampled with RX_D_VLD.
REQ-010 WrEn  out  1  register-file write strobe, one-cycle pulse.
REQ-011 RdEn  out  1  register-file read strobe, one-cycle pulse.
REQ-012 Address  out  ADDR_WIDTH  register-file address.
REQ-013 WrData  out  DATA_WIDTH  register-file write data.
REQ-014 ALU_EN  out  1  ALU start, one-cycle pulse.
REQ-015 ALU_FUN  out  4  ALU function, held after the pulse.
REQ-016 CLK_GATE_EN  out  1  ALU clock-gate enable.
REQ-017 BUSY  out  1  high while any state other than IDLE.
REQ-018 CMD_ERR  out  1  one-cycle pulse on a discarded byte or an unknown command.

Function
REQ-019 Command codes: 0xAA reg write (addr, data); 0xBB reg read (addr); 0xCC ALU with operands (A, B, fun); 0xDD ALU without operands (fun).
REQ-020 FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN.
REQ-021 The FSM advances only on RX_D_VLD=1 with RX_PAR_ERR=0 and RX_STP_ERR=0 ("good byte"); all other cycles hold state.
REQ-022 IDLE transitions on a good byte: 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->OP_A, 0xDD->ALU_FUN.
REQ-023 IDLE, any other good byte: stay IDLE, pulse CMD_ERR.
REQ-024 WR_ADDR: latch Address=byte[ADDR_WIDTH-1:0], go to WR_DATA.
REQ-025 WR_DATA: WrData=byte, WrEn pulse, go to IDLE.
REQ-026 RD_ADDR: Address=byte LSBs, RdEn pulse, go to IDLE.
REQ-027 OP_A: Address=0, WrData=byte, WrEn pulse, go to OP_B.
REQ-028 OP_B: Address=1, WrData=byte, WrEn pulse, go to ALU_FUN.
REQ-029 ALU_FUN: ALU_FUN=byte[3:0], ALU_EN pulse, go to IDLE.
REQ-030 All outputs are registered; every strobe asserts in the cycle after the good byte that completes its field and lasts exactly one cycle.
REQ-031 CLK_GATE_EN sets in the cycle after the 0xCC/0xDD byte and clears in the cycle after the ALU_EN pulse.
REQ-032 Bad byte (RX_D_VLD=1 with RX_PAR_ERR or RX_STP_ERR) in any state: byte discarded, FSM to IDLE, CMD_ERR pulse next cycle, CLK_GATE_EN cleared.
REQ-033 Writes already issued before a bad byte (e.g. OP_A) are not undone.
REQ-034 Address, WrData and ALU_FUN hold their last value between strobes.
REQ-035 WrEn and RdEn are never high in the same cycle.
REQ-036 Back-to-back RX_D_VLD in consecutive cycles: each byte is processed in sequence with no byte dropped.

Reset
REQ-037 RST=0 asynchronously forces IDLE; all outputs go to 0 (Address, WrData and ALU_FUN included).
REQ-038 Reset mid-command abandons the partial command; no strobe is issued for it after release.
REQ-039 After RST returns to 1, the first good byte is decoded as a command.

Verification
REQ-040 Bytes AA,05,3C -> one WrEn pulse with Address=5, WrData=0x3C; BUSY high from after the AA byte until the WrEn cycle.
REQ-041 Bytes BB,0F -> one RdEn pulse with Address=0xF; no WrEn.
REQ-042 Bytes CC,12,34,02 -> WrEn at Address=0, WrData=0x12; then WrEn at Address=1, WrData=0x34; then ALU_EN with ALU_FUN=2; CLK_GATE_EN spans CC through the ALU_EN cycle.
REQ-043 Bytes CC,12 then 34 with RX_PAR_ERR=1 -> first WrEn only, CMD_ERR pulse, IDLE, CLK_GATE_EN=0; a following DD,07 -> ALU_EN with ALU_FUN=7.
REQ-044 Byte 0x55 in IDLE -> CMD_ERR pulse, no strobes; RST low after AA,05 -> subsequent 3C produces no WrEn and a CMD_ERR pulse.
